muxn_scan: RTL and testbench
============================

MUXN_SCAN -- requirements
Module: muxn_scan

Interface
REQ-001 Parameter WIDTH, default 1: bit width of each data channel and of the output; legal range 1..32.
REQ-002 Parameter N, default 4: number of input channels; legal range 2..16; N need not be a power of two.
REQ-003 Local parameter SELW = ceil(log2(N)): width of select and channel-index signals.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in  input  N*WIDTH  packed channel data; channel k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-007 sel  input  SELW  manual channel select, sampled in MANUAL state only.
REQ-008 mode  input  1  0 = manual select, 1 = automatic scan.
REQ-009 en  input  1  block enable; 0 forces IDLE.
REQ-010 out  output  WIDTH  registered selected channel data.
REQ-011 cur_sel  output  SELW  registered index of the channel currently driven on out.
REQ-012 valid  output  1  registered; 1 when out holds data captured in the previous cycle.
REQ-013 wrap  output  1  registered one-cycle pulse, scan index passed N-1 -> 0.
REQ-014 err  output  1  registered; 1 when the manual sel captured in the previous cycle was >= N.

Function
REQ-015 FSM SHALL have exactly three states: IDLE, MANUAL, SCAN.
REQ-016 Transitions evaluated each rising edge: en=0 -> IDLE; en=1, mode=0 -> MANUAL; en=1, mode=1 -> SCAN; transitions are legal from any state to any state.
REQ-017 Latency SHALL be one cycle: out reflects in/sel values present at the preceding rising edge.
REQ-018 IDLE: out and cur_sel hold last values; valid=0, wrap=0, err=0.
REQ-019 MANUAL, sel < N: out <= channel sel, cur_sel <= sel, valid <= 1, err <= 0.
REQ-020 MANUAL, sel >= N: out <= 0, cur_sel <= sel, valid <= 1, err <= 1.
REQ-021 SCAN entry (previous state not SCAN): first captured channel is 0; cur_sel <= 0.
REQ-022 SCAN steady: each cycle index increments by 1; after N-1 next index is 0 (modulo N, never reaches values >= N).
REQ-023 wrap SHALL be 1 exactly in the cycle where cur_sel transitions from N-1 to 0 inside SCAN; never on SCAN entry.
REQ-024 In SCAN, err SHALL be 0 and sel SHALL be ignored.
REQ-025 Leaving SCAN then re-entering restarts at channel 0; no scan position is retained.
REQ-026 Changes on in between edges SHALL not affect out until the next rising edge.
REQ-027 mode changes with en=1 take effect at the next edge with no idle cycle; valid stays 1 across the switch.

Reset
REQ-028 reset=1 SHALL immediately, without a clock edge, force state IDLE, out=0, cur_sel=0, valid=0, wrap=0, err=0.
REQ-029 While reset=1, clk edges SHALL not change any output.
REQ-030 After reset deasserts, the first rising edge applies REQ-016 normally; reset mid-scan discards scan position.

Verification
REQ-031 WIDTH=8, N=4; in={8'hD4,8'hC3,8'hB2,8'hA1}, en=1, mode=0, sel=2 -> after 1 edge out=8'hC3, cur_sel=2, valid=1, err=0.
REQ-032 Same in, mode=1 held 6 edges -> cur_sel sequence 0,1,2,3,0,1; out A1,B2,C3,D4,A1,B2; wrap=1 only in the 5th cycle.
REQ-033 N=5, WIDTH=4, mode=0, sel=7 -> out=0, cur_sel=7, err=1, valid=1; then sel=4 -> out=channel 4, err=0.
REQ-034 SCAN at cur_sel=2, assert reset asynchronously mid-cycle -> out=0, cur_sel=0, valid=0 before next edge; release, mode=1 -> restarts at channel 0.
REQ-035 SCAN at cur_sel=1, en=0 for 2 edges -> valid=0, out/cur_sel held; en=1, mode=1 -> cur_sel=0, wrap=0.
REQ-036 SCAN to MANUAL switch with sel=3 -> next edge out=channel 3, valid stays 1, err=0, wrap=0.

Source files
------------

// File: rtl/muxn_scan_if.sv
// Channel-select bus for muxn_scan: packed channel data and controls in, registered selection out.
interface muxn_scan_if #(
  parameter int WIDTH = 1,
  parameter int N     = 4
);
  localparam int SELW = $clog2(N);

  logic [N*WIDTH-1:0] in;
  logic [SELW-1:0]    sel;
  logic               mode;
  logic               en;
  logic [WIDTH-1:0]   out;
  logic [SELW-1:0]    cur_sel;
  logic               valid;
  logic               wrap;
  logic               err;

  modport master (
    output in, sel, mode, en,
    input  out, cur_sel, valid, wrap, err
  );

  modport slave (
    input  in, sel, mode, en,
    output out, cur_sel, valid, wrap, err
  );
endinterface

// File: rtl/muxn_scan.sv
// N-way registered channel mux with manual select or automatic round-robin scan.
// One-cycle latency; IDLE holds out/cur_sel, and reset clears everything asynchronously.
module muxn_scan #(
  parameter int WIDTH = 1,
  parameter int N     = 4
) (
  input  logic        clk,
  input  logic        reset,
  muxn_scan_if.slave  bus
);
  localparam int SELW = $clog2(N);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [SELW-1:0]   cur_sel_q, cur_sel_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;

  logic [SELW-1:0]   scan_nxt;
  logic [SELW-1:0]   pick;
  logic [WIDTH-1:0]  chan_dat;
  logic              in_range;
  logic              at_last;

  // Scan position lives in cur_sel_q; it is only meaningful while already in SCAN.
  assign at_last  = (cur_sel_q == SELW'(N - 1));
  assign scan_nxt = (state_q != SCAN || at_last) ? '0 : cur_sel_q + SELW'(1);
  assign pick     = bus.mode ? scan_nxt : bus.sel;

  // Out-of-range selects (possible when N is not a power of two) match no channel.
  always_comb begin
    chan_dat = '0;
    in_range = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (pick == SELW'(k)) begin
        chan_dat = bus.in[k*WIDTH +: WIDTH];
        in_range = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    cur_sel_d = cur_sel_q;
    valid_d   = 1'b0;
    wrap_d    = 1'b0;
    err_d     = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
    end else if (!bus.mode) begin
      state_d   = MANUAL;
      cur_sel_d = bus.sel;
      out_d     = in_range ? chan_dat : '0;
      valid_d   = 1'b1;
      err_d     = !in_range;
    end else begin
      state_d   = SCAN;
      cur_sel_d = scan_nxt;
      out_d     = chan_dat;
      valid_d   = 1'b1;
      wrap_d    = (state_q == SCAN) && at_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      out_q     <= '0;
      cur_sel_q <= '0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      cur_sel_q <= cur_sel_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.cur_sel = cur_sel_q;
  assign bus.valid   = valid_q;
  assign bus.wrap    = wrap_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_muxn_scan.sv
// Bench for muxn_scan: two instances (8x4 and 4x5) against a behavioural model plus directed literal checks.
module tb_muxn_scan;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  muxn_scan_if #(.WIDTH(8), .N(4)) if_a ();
  muxn_scan_if #(.WIDTH(4), .N(5)) if_b ();

  muxn_scan #(.WIDTH(8), .N(4)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  muxn_scan #(.WIDTH(4), .N(5)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

  typedef struct {
    logic [31:0] out;
    logic [31:0] cur;
    logic [31:0] valid;
    logic [31:0] wrap;
    logic [31:0] err;
    bit          scanning;
  } mst_t;

  mst_t ma = '{default: 0};
  mst_t mb = '{default: 0};

  function automatic logic [31:0] chan(logic [63:0] inv, int k, int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return 32'((inv >> (k * w)) & mask);
  endfunction

  // Behaviour from the rules: positions count modulo n from 0 on each fresh scan entry.
  function automatic mst_t step(mst_t s, int n, int w, logic [63:0] inv, int sel, bit en, bit mode);
    mst_t r;
    r = s;
    r.wrap = 0;
    r.err  = 0;
    if (!en) begin
      r.valid    = 0;
      r.scanning = 0;
    end else if (!mode) begin
      r.valid    = 1;
      r.scanning = 0;
      r.cur      = 32'(sel);
      if (sel < n) r.out = chan(inv, sel, w);
      else begin
        r.out = 0;
        r.err = 1;
      end
    end else begin
      if (s.scanning) begin
        r.cur  = (s.cur + 1) % n;
        r.wrap = (r.cur == 0) ? 1 : 0;
      end else begin
        r.cur = 0;
      end
      r.scanning = 1;
      r.valid    = 1;
      r.out      = chan(inv, int'(r.cur), w);
    end
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ma = '{default: 0};
      mb = '{default: 0};
    end else begin
      ma = step(ma, 4, 8, 64'(if_a.in), int'(if_a.sel), if_a.en, if_a.mode);
      mb = step(mb, 5, 4, 64'(if_b.in), int'(if_b.sel), if_b.en, if_b.mode);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("a_out",   32'(if_a.out),     ma.out);
    chk("a_cur",   32'(if_a.cur_sel), ma.cur);
    chk("a_valid", 32'(if_a.valid),   ma.valid);
    chk("a_wrap",  32'(if_a.wrap),    ma.wrap);
    chk("a_err",   32'(if_a.err),     ma.err);
    chk("b_out",   32'(if_b.out),     mb.out);
    chk("b_cur",   32'(if_b.cur_sel), mb.cur);
    chk("b_valid", 32'(if_b.valid),   mb.valid);
    chk("b_wrap",  32'(if_b.wrap),    mb.wrap);
    chk("b_err",   32'(if_b.err),     mb.err);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl(bit en, bit mode);
    if_a.en = en;  if_a.mode = mode;
    if_b.en = en;  if_b.mode = mode;
  endtask

  task automatic chk_a(string tag, logic [31:0] o, logic [31:0] c, logic [31:0] v, logic [31:0] wr, logic [31:0] e);
    chk({tag, "_out"},   32'(if_a.out),     o);
    chk({tag, "_cur"},   32'(if_a.cur_sel), c);
    chk({tag, "_valid"}, 32'(if_a.valid),   v);
    chk({tag, "_wrap"},  32'(if_a.wrap),    wr);
    chk({tag, "_err"},   32'(if_a.err),     e);
  endtask

  logic [7:0] scan_out [6];
  int         scan_cur [6];

  initial begin
    scan_out = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hA1, 8'hB2};
    scan_cur = '{0, 1, 2, 3, 0, 1};
    if_a.in = 32'hD4C3B2A1; if_a.sel = 2'd2;
    if_b.in = 20'hEDCBA;    if_b.sel = 3'd2;
    ctrl(0, 0);
    #1 reset = 1'b1;
    #2;
    chk_a("rst0", 0, 0, 0, 0, 0);
    chk("rst0_b_out", 32'(if_b.out), 0);
    tick();
    #3 reset = 1'b0;

    // Manual select of channel 2.
    ctrl(1, 0);
    tick();
    chk_a("man2", 32'hC3, 2, 1, 0, 0);
    chk("model_man2", ma.out, 32'hC3);

    // Six scan cycles from entry; wrap only on the 3 -> 0 step.
    ctrl(1, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_a($sformatf("scan%0d", i), 32'(scan_out[i]), 32'(scan_cur[i]), 1, (i == 4) ? 1 : 0, 0);
    end
    chk("model_scan_cur", ma.cur, 1);

    // Idle for two edges holds out/cur_sel, then re-entry restarts at 0.
    ctrl(0, 1);
    tick();
    tick();
    chk_a("idle", 32'hB2, 1, 0, 0, 0);
    ctrl(1, 1);
    tick();
    chk_a("reent", 32'hA1, 0, 1, 0, 0);
    tick();
    tick();
    chk("pre_rst_cur", 32'(if_a.cur_sel), 2);

    // Asynchronous reset mid-cycle, held across one edge.
    #2 reset = 1'b1;
    #1;
    chk_a("arst", 0, 0, 0, 0, 0);
    tick();
    chk_a("arst_hold", 0, 0, 0, 0, 0);
    reset = 1'b0;
    ctrl(1, 1);
    tick();
    chk_a("post_rst", 32'hA1, 0, 1, 0, 0);

    // SCAN to MANUAL switch without an idle cycle.
    tick();
    tick();
    if_a.sel = 2'd3;
    ctrl(1, 0);
    tick();
    chk_a("sw_man", 32'hD4, 3, 1, 0, 0);

    // Out-of-range select on the five-channel instance.
    if_b.sel = 3'd7;
    tick();
    chk("b_oor_out", 32'(if_b.out), 0);
    chk("b_oor_cur", 32'(if_b.cur_sel), 7);
    chk("b_oor_err", 32'(if_b.err), 1);
    chk("b_oor_valid", 32'(if_b.valid), 1);
    chk("model_b_err", mb.err, 1);
    if_b.sel = 3'd4;
    tick();
    chk("b_ch4_out", 32'(if_b.out), 32'hE);
    chk("b_ch4_cur", 32'(if_b.cur_sel), 4);
    chk("b_ch4_err", 32'(if_b.err), 0);

    // Randomized traffic; mode tends to persist so full scans and wraps occur.
    for (int i = 0; i < 3000; i++) begin
      ctrl(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0) ? ~if_a.mode : if_a.mode);
      if_b.en = if_a.en;
      if_b.mode = if_a.mode;
      if_a.sel = 2'($urandom);
      if_b.sel = 3'($urandom);
      if_a.in = $urandom;
      if_b.in = 20'($urandom);
      #2;
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        if_a.in = $urandom;
        if_b.in = 20'($urandom);
        tick();
      end
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
